// File: rtl/llc_req_decoder.sv
// Front-end of the LLC controller: filters illegal trace opcodes, buffers legal commands
// in order, and presents each as a registered request split into tag/index/offset plus class flags.
module llc_req_decoder #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 14,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_n,
    input  logic [ADDR_W-1:0]   in_addr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_n,
    output logic [TAG_W-1:0]    out_tag,
    output logic [INDEX_W-1:0]  out_index,
    output logic [OFFSET_W-1:0] out_offset,
    output logic                out_is_cpu,
    output logic                out_is_snoop,
    output logic                out_is_ctrl,
    output logic [CNT_W-1:0]    illegal_cnt
);
    localparam int AW      = $clog2(DEPTH);
    localparam int PTR_W   = AW + 1;
    localparam int ENTRY_W = 4 + ADDR_W;

    logic [ENTRY_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic                r_out_valid;
    logic [3:0]          r_out_n;
    logic [TAG_W-1:0]    r_out_tag;
    logic [INDEX_W-1:0]  r_out_index;
    logic [OFFSET_W-1:0] r_out_offset;
    logic                r_out_is_cpu;
    logic                r_out_is_snoop;
    logic                r_out_is_ctrl;
    logic [CNT_W-1:0]    r_illegal_cnt;

    logic                w_empty;
    logic                w_full;
    logic                w_accept;
    logic                w_legal;
    logic                w_push_legal;
    logic                w_push_illegal;
    logic                w_load;
    logic                w_src_avail;
    logic                w_fifo_wr;
    logic                w_fifo_rd;
    logic [ENTRY_W-1:0]  w_head;
    logic [3:0]          w_src_n;
    logic [ADDR_W-1:0]   w_src_addr;
    logic                w_dec_cpu;
    logic                w_dec_snoop;
    logic                w_dec_ctrl;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Opcodes 7 and 10..15 are dropped but still handshaken so the trace keeps flowing.
    assign w_legal        = (in_n != 4'd7) && (in_n < 4'd10);
    assign w_accept       = in_valid && in_ready;
    assign w_push_legal   = w_accept && w_legal;
    assign w_push_illegal = w_accept && !w_legal;

    assign w_load      = !r_out_valid || out_ready;
    assign w_src_avail = !w_empty || w_push_legal;
    // With an empty FIFO the incoming command bypasses straight into the output register.
    assign w_fifo_rd   = w_load && !w_empty;
    assign w_fifo_wr   = w_push_legal && !(w_load && w_empty);

    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_src_n    = w_empty ? in_n    : w_head[ENTRY_W-1 -: 4];
    assign w_src_addr = w_empty ? in_addr : w_head[ADDR_W-1:0];

    assign w_dec_cpu   = (w_src_n <= 4'd2);
    assign w_dec_snoop = (w_src_n >= 4'd3) && (w_src_n <= 4'd6);
    assign w_dec_ctrl  = (w_src_n == 4'd8) || (w_src_n == 4'd9);

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {in_n, in_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_out_valid    <= 1'b0;
            r_out_n        <= '0;
            r_out_tag      <= '0;
            r_out_index    <= '0;
            r_out_offset   <= '0;
            r_out_is_cpu   <= 1'b0;
            r_out_is_snoop <= 1'b0;
            r_out_is_ctrl  <= 1'b0;
            r_illegal_cnt  <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_fifo_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_load) begin
                if (w_src_avail) begin
                    r_out_valid    <= 1'b1;
                    r_out_n        <= w_src_n;
                    r_out_tag      <= w_src_addr[ADDR_W-1 -: TAG_W];
                    r_out_index    <= w_src_addr[OFFSET_W +: INDEX_W];
                    r_out_offset   <= w_src_addr[OFFSET_W-1:0];
                    r_out_is_cpu   <= w_dec_cpu;
                    r_out_is_snoop <= w_dec_snoop;
                    r_out_is_ctrl  <= w_dec_ctrl;
                end else begin
                    r_out_valid    <= 1'b0;
                    r_out_n        <= '0;
                    r_out_tag      <= '0;
                    r_out_index    <= '0;
                    r_out_offset   <= '0;
                    r_out_is_cpu   <= 1'b0;
                    r_out_is_snoop <= 1'b0;
                    r_out_is_ctrl  <= 1'b0;
                end
            end
            if (w_push_illegal && (r_illegal_cnt != '1)) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready     = !w_full;
    assign out_valid    = r_out_valid;
    assign out_n        = r_out_n;
    assign out_tag      = r_out_tag;
    assign out_index    = r_out_index;
    assign out_offset   = r_out_offset;
    assign out_is_cpu   = r_out_is_cpu;
    assign out_is_snoop = r_out_is_snoop;
    assign out_is_ctrl  = r_out_is_ctrl;
    assign illegal_cnt  = r_illegal_cnt;

endmodule
